dest_reader: RTL and testbench
==============================

DEST_READER -- requirements
Module: dest_reader

Interface
REQ-001 Parameter BW, default 6, width of data words popped from destination FIFOs D0/D1.
REQ-002 Parameter CW, default 5, width of each per-destination word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  enable; 1 = block may pop FIFOs, 0 = no new pops.
REQ-006 hold  input  1  downstream stall; 1 = no new pops (in-flight word still completes).
REQ-007 D0_empty, D1_empty  input  1 each  FIFO empty flags.
REQ-008 D0_error_output, D1_error_output  input  1 each  FIFO error flags.
REQ-009 D0_data_out, D1_data_out  input  BW each  FIFO read data, valid the cycle after the matching rd pulse.
REQ-010 D0_rd, D1_rd  output  1 each  FIFO pop strobes, registered.
REQ-011 data_out  output  BW  popped word; valid_out  output  1  data_out qualifier; dest_out  output  1  source FIFO (0 = D0, 1 = D1).
REQ-012 cnt_req  input  1, cnt_idx  input  1  counter read request and index.
REQ-013 cnt_out  output  CW, cnt_valid  output  1  counter read response.
REQ-014 error_flag  output  1  sticky; set when either FIFO error input is seen at 1.

Function
REQ-015 FSM states IDLE and ACTIVE; IDLE->ACTIVE when init=1, ACTIVE->IDLE when init=0; state checked every cycle.
REQ-016 FIFO Dn is eligible in a cycle iff state=ACTIVE, hold=0, Dn_empty=0, Dn_error_output=0, and Dn_rd was not asserted in the previous cycle.
REQ-017 At most one of D0_rd/D1_rd is asserted per cycle; never both.
REQ-018 Both eligible -> pop the FIFO not served last (round-robin); one eligible -> pop it; none -> no pop.
REQ-019 Last-served pointer updates only on an issued pop.
REQ-020 Pop issued in cycle N (rd=1) -> Dn_data_out captured at end of cycle N+1 -> valid_out=1 with data_out and dest_out during cycle N+2, for exactly one cycle.
REQ-021 An issued pop always completes to valid_out regardless of later init, hold or error changes.
REQ-022 valid_out=0 -> data_out and dest_out hold previous value.
REQ-023 Counter n increments by 1 in the cycle valid_out=1 with dest_out=n; wraps 2^CW-1 -> 0.
REQ-024 cnt_req=1 in cycle N -> cnt_valid=1 and cnt_out=counter[cnt_idx] in N+1; same-cycle increment is not visible until the following request.
REQ-025 cnt_req=0 -> cnt_valid=0 next cycle, cnt_out holds.
REQ-026 error_flag set at end of any cycle where D0_error_output or D1_error_output=1; cleared only by reset.

Reset
REQ-027 reset=1 at an edge -> state IDLE, D0_rd=D1_rd=0, valid_out=0, data_out=0, dest_out=0, counters=0, cnt_out=0, cnt_valid=0, error_flag=0, last-served pointer=D1 (first pop favours D0).
REQ-028 reset mid-operation discards any in-flight pop; no valid_out follows it.

Structure
REQ-029 Shared package holds BW, CW defaults and state encodings IDLE=0, ACTIVE=1.
REQ-030 One sub-module, rr_arbiter2: two-requester round-robin arbiter with grant and pointer register.

Verification
REQ-031 Reset, init=1, D0 nonempty holding 6'h05, D1 empty -> D0_rd in cycle 1, valid_out with data_out=6'h05, dest_out=0 in cycle 3.
REQ-032 Both FIFOs hold 3 words, hold=0 -> pops alternate D0,D1,D0,D1,D0,D1; no back-to-back rd on the same FIFO.
REQ-033 hold=1 right after a D1 pop issues -> that word still appears on valid_out; no further rd until hold=0.
REQ-034 D1_error_output=1 with D1 nonempty -> D1_rd never asserted, error_flag=1 until reset, D0 still served.
REQ-035 33 pops from D0 with CW=5 -> cnt_req=1, cnt_idx=0 returns cnt_out=1 with cnt_valid=1 one cycle later.
REQ-036 reset=1 in the cycle after a pop issues -> no valid_out, all outputs at reset values.

Source files
------------

// File: rtl/dest_reader_pkg.sv
// Shared definitions for the destination-FIFO reader: default widths,
// FSM state encoding and last-served pointer values.
package dest_reader_pkg;

    localparam int unsigned BW_DEF = 6;
    localparam int unsigned CW_DEF = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic PTR_D0 = 1'b0;
    localparam logic PTR_D1 = 1'b1;

endpackage

// File: rtl/dest_reader_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers the last
// requester granted and moves only when a grant is actually issued.
module rr_arbiter2
    import dest_reader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == PTR_D1) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PTR_D1;
        end else if (grant[0]) begin
            last_q <= PTR_D0;
        end else if (grant[1]) begin
            last_q <= PTR_D1;
        end
    end

endmodule

// File: rtl/dest_reader.sv
// Pops words from two destination FIFOs in round-robin order, presents each
// popped word two cycles after its read strobe, and keeps per-FIFO word counts.
module dest_reader
    import dest_reader_pkg::*;
#(
    parameter int unsigned BW = BW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          hold,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic          D0_error_output,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          dest_out,
    input  logic          cnt_req,
    input  logic          cnt_idx,
    output logic [CW-1:0] cnt_out,
    output logic          cnt_valid,
    output logic          error_flag
);

    state_t state_q, state_d;
    logic [1:0] req, grant;
    logic pend_q, pend_dest_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init)  state_d = ACTIVE;
            ACTIVE:  if (!init) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A FIFO whose strobe is high this cycle sits out one cycle, so its
    // empty flag has caught up before it can be popped again.
    always_comb begin
        req    = '0;
        req[0] = (state_q == ACTIVE) && !hold && !D0_empty && !D0_error_output && !D0_rd;
        req[1] = (state_q == ACTIVE) && !hold && !D1_empty && !D1_error_output && !D1_rd;
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            D0_rd       <= 1'b0;
            D1_rd       <= 1'b0;
            pend_q      <= 1'b0;
            pend_dest_q <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            dest_out    <= 1'b0;
        end else begin
            D0_rd       <= grant[0];
            D1_rd       <= grant[1];
            pend_q      <= D0_rd | D1_rd;
            pend_dest_q <= D1_rd;
            valid_out   <= pend_q;
            if (pend_q) begin
                data_out <= pend_dest_q ? D1_data_out : D0_data_out;
                dest_out <= pend_dest_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            cnt_out    <= '0;
            cnt_valid  <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            if (valid_out) cnt_q[dest_out] <= cnt_q[dest_out] + 1'b1;
            if (cnt_req)   cnt_out <= cnt_q[cnt_idx];
            cnt_valid  <= cnt_req;
            error_flag <= error_flag | D0_error_output | D1_error_output;
        end
    end

endmodule

// File: tb/tb_dest_reader.sv
// Directed bench for dest_reader: FIFO models feed the DUT, a negedge monitor
// logs strobes and output words, and each scenario checks hand-computed results.
module tb_dest_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       hold = 1'b0;
    logic       D0_empty, D1_empty;
    logic       D0_error_output = 1'b0;
    logic       D1_error_output = 1'b0;
    logic [5:0] D0_data_out = '0;
    logic [5:0] D1_data_out = '0;
    logic       D0_rd, D1_rd;
    logic [5:0] data_out;
    logic       valid_out, dest_out;
    logic       cnt_req = 1'b0;
    logic       cnt_idx = 1'b0;
    logic [4:0] cnt_out;
    logic       cnt_valid, error_flag;

    dest_reader #(.BW(6), .CW(5)) dut (
        .clk(clk), .reset(reset), .init(init), .hold(hold),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .data_out(data_out), .valid_out(valid_out), .dest_out(dest_out),
        .cnt_req(cnt_req), .cnt_idx(cnt_idx), .cnt_out(cnt_out),
        .cnt_valid(cnt_valid), .error_flag(error_flag)
    );

    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after a strobe
    logic [5:0] mem0 [64];
    logic [5:0] mem1 [64];
    logic [5:0] rp0 = '0, wp0 = '0, rp1 = '0, wp1 = '0;
    assign D0_empty = (rp0 == wp0);
    assign D1_empty = (rp1 == wp1);

    always @(posedge clk) begin
        if (D0_rd) begin D0_data_out <= mem0[rp0]; rp0 <= rp0 + 6'd1; end
        if (D1_rd) begin D1_data_out <= mem1[rp1]; rp1 <= rp1 + 6'd1; end
    end

    int         rd0_n, rd1_n, both_n;
    int         rd_seq [$];
    logic [5:0] vdata [$];
    logic       vdest [$];

    always @(negedge clk) begin
        if (D0_rd && D1_rd) both_n++;
        if (D0_rd) begin rd0_n++; rd_seq.push_back(0); end
        if (D1_rd) begin rd1_n++; rd_seq.push_back(1); end
        if (valid_out) begin vdata.push_back(data_out); vdest.push_back(dest_out); end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [5:0] d);
        mem0[wp0] = d;
        wp0 = wp0 + 6'd1;
    endtask

    task automatic push1(input logic [5:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 6'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rd0_n = 0; rd1_n = 0; both_n = 0;
        rd_seq.delete(); vdata.delete(); vdest.delete();
    endtask

    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
    logic [5:0] exp_data [6] = '{6'h11, 6'h21, 6'h12, 6'h22, 6'h13, 6'h23};

    initial begin
        // Reset state
        do_reset();
        tick();
        check("rst_d0_rd", D0_rd, 0);
        check("rst_d1_rd", D1_rd, 0);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_dest", dest_out, 0);
        check("rst_cnt_out", cnt_out, 0);
        check("rst_cnt_valid", cnt_valid, 0);
        check("rst_err", error_flag, 0);

        // Single word from D0: strobe then data two cycles later
        init = 1'b1;
        push0(6'h05);
        do_reset();
        tick();
        check("lat_rd_early", D0_rd, 0);
        tick();
        check("lat_d0_rd", D0_rd, 1);
        check("lat_d1_rd", D1_rd, 0);
        tick();
        check("lat_rd_one", D0_rd, 0);
        check("lat_valid_early", valid_out, 0);
        tick();
        check("lat_valid", valid_out, 1);
        check("lat_data", data_out, 6'h05);
        check("lat_dest", dest_out, 0);
        tick();
        check("lat_valid_one", valid_out, 0);
        check("lat_data_hold", data_out, 6'h05);

        // Round-robin alternation with both FIFOs full
        init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push0(6'h11 + 6'(i));
            push1(6'h21 + 6'(i));
        end
        init = 1'b1;
        do_reset();
        repeat (20) tick();
        check("rr_rd_count", rd_seq.size(), 6);
        check("rr_both", both_n, 0);
        check("rr_valid_count", vdata.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rd_seq.size()) check("rr_order", rd_seq[i], exp_seq[i]);
            if (i < vdata.size()) begin
                check("rr_data", vdata[i], exp_data[i]);
                check("rr_dest", vdest[i], exp_seq[i][0]);
            end
        end
        cnt_req = 1'b1; cnt_idx = 1'b1;
        tick();
        cnt_req = 1'b0;
        check("rr_cnt1_valid", cnt_valid, 1);
        check("rr_cnt1", cnt_out, 3);

        // Hold raised right after a D1 pop issues
        init = 1'b0;
        push1(6'h31);
        push1(6'h32);
        init = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && !D1_rd; i++) tick();
        check("hold_rd_seen", D1_rd, 1);
        hold = 1'b1;
        repeat (6) tick();
        check("hold_rd_count", rd1_n, 1);
        check("hold_valid_count", vdata.size(), 1);
        if (vdata.size() > 0) begin
            check("hold_data", vdata[0], 6'h31);
            check("hold_dest", vdest[0], 1);
        end
        hold = 1'b0;
        repeat (6) tick();
        check("hold_release_rd", rd1_n, 2);
        check("hold_release_valid", vdata.size(), 2);
        if (vdata.size() > 1) check("hold_release_data", vdata[1], 6'h32);

        // D1 error: D1 never served, D0 still served, sticky flag
        init = 1'b0;
        push0(6'h0B);
        push1(6'h3A);
        D1_error_output = 1'b1;
        init = 1'b1;
        do_reset();
        repeat (10) tick();
        check("err_d1_rd", rd1_n, 0);
        check("err_flag", error_flag, 1);
        check("err_d0_served", vdata.size(), 1);
        if (vdata.size() > 0) check("err_d0_data", vdata[0], 6'h0B);
        D1_error_output = 1'b0;
        repeat (6) tick();
        check("err_sticky", error_flag, 1);
        init = 1'b0;
        do_reset();
        tick();
        check("err_cleared", error_flag, 0);

        // 33 D0 words: 5-bit counter wraps to 1
        for (int i = 0; i < 33; i++) push0(6'(i));
        init = 1'b1;
        do_reset();
        repeat (80) tick();
        check("wrap_valid_count", vdata.size(), 33);
        cnt_req = 1'b1; cnt_idx = 1'b0;
        tick();
        check("wrap_cnt_valid", cnt_valid, 1);
        check("wrap_cnt0", cnt_out, 1);
        cnt_idx = 1'b1;
        tick();
        check("wrap_cnt1", cnt_out, 0);
        cnt_req = 1'b0;
        tick();
        check("cnt_idle_valid", cnt_valid, 0);
        check("cnt_idle_hold", cnt_out, 0);

        // Reset in the cycle after a pop issues
        init = 1'b0;
        push0(6'h2C);
        init = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && !D0_rd; i++) tick();
        check("rstmid_rd_seen", D0_rd, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rstmid_no_valid", vdata.size(), 0);
        check("rstmid_data", data_out, 0);
        check("rstmid_dest", dest_out, 0);
        check("rstmid_rd", {30'd0, D1_rd, D0_rd}, 0);
        check("rstmid_err", error_flag, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
